// File: rtl/mas16_pkg.sv
// Shared definitions for the 16-bit core execute stage: widths, opcodes, FSM encoding.
package mas16_pkg;

  localparam int WIDTH      = 16;
  localparam int NREGISTERS = 4;
  localparam int RIDX_W     = $clog2(NREGISTERS);

  typedef logic [2:0]        opcode_t;
  typedef logic [RIDX_W-1:0] ridx_t;
  typedef logic [WIDTH-1:0]  word_t;

  localparam opcode_t OP_ADD = 3'b000;
  localparam opcode_t OP_SUB = 3'b001;
  localparam opcode_t OP_AND = 3'b010;
  localparam opcode_t OP_OR  = 3'b011;
  localparam opcode_t OP_XOR = 3'b100;
  localparam opcode_t OP_SHL = 3'b101;
  localparam opcode_t OP_SHR = 3'b110;
  localparam opcode_t OP_MUL = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

endpackage

// File: rtl/ex16b_unit_if.sv
// Issue / write-back bundle between the register file and the execute stage.
// master = instruction source, slave = execute unit.
interface ex16b_unit_if;
  import mas16_pkg::*;

  logic    valid_in;
  logic    ready_out;
  opcode_t op;
  ridx_t   rd_in;
  word_t   opA;
  word_t   opB;
  ridx_t   wb_rd;
  word_t   wb_data;
  logic    wb_en;
  logic    flag_z;
  logic    flag_c;

  modport master (
    output valid_in, op, rd_in, opA, opB,
    input  ready_out, wb_rd, wb_data, wb_en, flag_z, flag_c
  );

  modport slave (
    input  valid_in, op, rd_in, opA, opB,
    output ready_out, wb_rd, wb_data, wb_en, flag_z, flag_c
  );

endinterface

// File: rtl/mul16_seq.sv
// Sequential 16x16 shift-add multiplier: operands latched on start, one iteration per cycle.
// done marks the 16th iteration; product then shows the final accumulator combinationally.
module mul16_seq
  import mas16_pkg::*;
(
  input  logic              clk,
  input  logic              rstz,
  input  logic              start,
  input  word_t             a,
  input  word_t             b,
  output logic              done,
  output logic [2*WIDTH-1:0] product
);

  logic                busy_q,   busy_d;
  logic [3:0]          cnt_q,    cnt_d;
  logic [2*WIDTH-1:0]  acc_q,    acc_d;
  logic [2*WIDTH-1:0]  mcand_q,  mcand_d;
  word_t               mplier_q, mplier_d;
  logic [2*WIDTH-1:0]  acc_step;

  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = 4'd0;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
    end else if (busy_q) begin
      busy_d   = (cnt_q != 4'd15);
      cnt_d    = cnt_q + 4'd1;
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  // Exposing the in-flight sum lets write-back capture the result on the same edge as the last add.
  assign done    = busy_q && (cnt_q == 4'd15);
  assign product = acc_step;

endmodule

// File: rtl/ex16b_unit.sv
// Execute stage: ALU ops write back 1 cycle after accept, MUL 17 cycles after accept.
// Accepts only in IDLE (ready_out); valid_in while busy is ignored and must be held.
module ex16b_unit
  import mas16_pkg::*;
(
  input  logic clk,
  input  logic rstz,
  inout  wire  dvdd,
  inout  wire  dgnd,
  ex16b_unit_if.slave bus
);

  logic [1:0] state_q,   state_d;
  ridx_t      rd_q,      rd_d;
  ridx_t      wb_rd_q,   wb_rd_d;
  word_t      wb_data_q, wb_data_d;
  logic       flag_z_q,  flag_z_d;
  logic       flag_c_q,  flag_c_d;

  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  word_t              alu_data;
  logic               alu_c;
  logic [WIDTH:0]     sum17;
  logic [3:0]         sh;
  logic [3:0]         shl_idx;
  logic               unused_pwr;

  assign unused_pwr = dvdd ^ dgnd;

  assign accept    = bus.valid_in && (state_q == ST_IDLE);
  assign mul_start = accept && (bus.op == OP_MUL);

  mul16_seq u_mul (
    .clk     (clk),
    .rstz    (rstz),
    .start   (mul_start),
    .a       (bus.opA),
    .b       (bus.opB),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    alu_data = '0;
    alu_c    = 1'b0;
    sh       = bus.opB[3:0];
    shl_idx  = 4'd0 - sh;
    sum17    = {1'b0, bus.opA} + {1'b0, bus.opB};
    case (bus.op)
      OP_ADD: begin
        alu_data = sum17[WIDTH-1:0];
        alu_c    = sum17[WIDTH];
      end
      OP_SUB: begin
        alu_data = bus.opA - bus.opB;
        alu_c    = (bus.opA < bus.opB);
      end
      OP_AND: alu_data = bus.opA & bus.opB;
      OP_OR:  alu_data = bus.opA | bus.opB;
      OP_XOR: alu_data = bus.opA ^ bus.opB;
      // Carry is the last bit pushed out: opA[16-sh] left, opA[sh-1] right.
      OP_SHL: begin
        alu_data = bus.opA << sh;
        alu_c    = (sh != 4'd0) && bus.opA[shl_idx];
      end
      OP_SHR: begin
        alu_data = bus.opA >> sh;
        alu_c    = (sh != 4'd0) && bus.opA[sh - 4'd1];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rd_d = bus.rd_in;
          if (bus.op == OP_MUL) begin
            state_d = ST_MUL;
          end else begin
            state_d   = ST_WB;
            wb_rd_d   = bus.rd_in;
            wb_data_d = alu_data;
            flag_z_d  = (alu_data == '0);
            flag_c_d  = alu_c;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d   = ST_WB;
          wb_rd_d   = rd_q;
          wb_data_d = mul_product[WIDTH-1:0];
          flag_z_d  = (mul_product[WIDTH-1:0] == '0);
          flag_c_d  = |mul_product[2*WIDTH-1:WIDTH];
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q   <= ST_IDLE;
      rd_q      <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      flag_z_q  <= flag_z_d;
      flag_c_q  <= flag_c_d;
    end
  end

  assign bus.ready_out = (state_q == ST_IDLE);
  assign bus.wb_en     = (state_q == ST_WB);
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_c    = flag_c_q;

endmodule
